// File: rtl/pc_seq_if.sv
// Fetch-stage control bundle between the redirect/stall sources and the PC sequencer.
// master drives the requests and observes the PC; slave is the sequencer itself.
interface pc_seq_if #(
  parameter int PC_W = 10
);
  logic            stall;
  logic            halt;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next_seq;
  logic            pc_valid;
  logic            ras_underflow;

  // Handshake: no valid/ready pair here. Requests are level inputs sampled on
  // every rising clk edge; pc/pc_valid reflect the registered state for that cycle.
  modport master (
    output stall, halt, br_taken, br_target, jmp, jmp_target, call, ret,
    input  pc, pc_next_seq, pc_valid, ras_underflow
  );

  modport slave (
    input  stall, halt, br_taken, br_target, jmp, jmp_target, call, ret,
    output pc, pc_next_seq, pc_valid, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT/RUN/HALT FSM with stall, branch and jump redirects.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int RESET_PC  = 0,
  parameter int PC_INC    = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_seq_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_INC_V   = PC_W'(PC_INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            ras_push, ras_pop, ras_ok, uf_d, uf_q;
  logic [PC_W-1:0] ras_top;

  assign pc_inc          = pc_q + PC_INC_V;
  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = pc_inc;
  assign bus.ras_underflow = uf_q;

`ifdef PC_SEQ_RAS_EN
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   ras_wp;
  logic [CW-1:0]   ras_cnt;

  // Circular buffer: a push into a full stack overwrites the oldest entry.
  assign ras_top = ras_mem[ras_wp - AW'(1)];
  assign ras_ok  = bus.ret && (ras_cnt != '0);
  assign uf_d    = (state == ST_RUN) && bus.ret && (ras_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
    end else if (ras_pop) begin
      ras_wp  <= ras_wp - AW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end else if (ras_push) begin
      ras_mem[ras_wp] <= pc_inc;
      ras_wp          <= ras_wp + AW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end
  end
`else
  assign ras_top = '0;
  assign ras_ok  = 1'b0;
  assign uf_d    = 1'b0;
  wire unused_ras = &{1'b0, bus.ret, ras_push, ras_pop};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc_q  <= RESET_PC_V;
      uf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_d;
      uf_q  <= uf_d;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_d      = pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (ras_ok) begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end else if (bus.jmp) begin
          pc_d     = bus.jmp_target;
          ras_push = bus.call;
        end else if (bus.br_taken) begin
          pc_d = bus.br_target;
        end else if (bus.halt) begin
          state_nxt = ST_HALT;
        end else if (!bus.stall) begin
          pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        // Only a redirect leaves HALT; stall and ret have no effect here.
        if (bus.jmp) begin
          pc_d      = bus.jmp_target;
          state_nxt = ST_RUN;
        end else if (bus.br_taken) begin
          pc_d      = bus.br_target;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    bus.pc_valid = (state == ST_RUN);
    dbg_state    = state;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_W=10, RESET_PC=0, PC_INC=1, RAS_DEPTH=4).
// Expectations follow the stack behaviour when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  pc_seq_if #(.PC_W(10)) bus ();

  pc_sequencer #(
    .PC_W(10), .RESET_PC(0), .PC_INC(1), .RAS_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic exp_valid);
    check({tag, "_pc"}, 32'(bus.pc), exp_pc);
    check({tag, "_valid"}, 32'(bus.pc_valid), 32'(exp_valid));
  endtask

  task automatic jump_to(input logic [9:0] tgt, input logic is_call);
    bus.jmp = 1'b1; bus.jmp_target = tgt; bus.call = is_call;
    step();
    bus.jmp = 1'b0; bus.call = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.stall = 0; bus.halt = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.jmp = 0; bus.jmp_target = '0; bus.call = 0; bus.ret = 0;

    // Reset and boot
    reset = 1'b1;
    step(); step();
    check_pc("reset", 0, 1'b0);
    check("reset_state", 32'(dbg_state), 0);
    check("reset_uf", 32'(bus.ras_underflow), 0);
    check("reset_nseq", 32'(bus.pc_next_seq), 1);
    reset = 1'b0;
    #1;
    check_pc("boot", 0, 1'b0);
    step(); check_pc("run0", 0, 1'b1);
    step(); check_pc("run1", 1, 1'b1);
    step(); check_pc("run2", 2, 1'b1);
    step(); check_pc("run3", 3, 1'b1);

    // Stall and wrap-around
    jump_to(10'd1022, 1'b0);
    check_pc("jmp1022", 1022, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_pc("stall", 1022, 1'b1);
    end
    bus.stall = 1'b0;
    step(); check_pc("inc1023", 1023, 1'b1);
    check("nseq_wrap", 32'(bus.pc_next_seq), 0);
    step(); check_pc("wrap0", 0, 1'b1);

    // Redirect priority: jmp beats br_taken and stall
    jump_to(10'd5, 1'b0);
    check_pc("jmp5", 5, 1'b1);
    bus.jmp = 1; bus.jmp_target = 10'd200;
    bus.br_taken = 1; bus.br_target = 10'd50; bus.stall = 1;
    step(); check_pc("prio_jmp", 200, 1'b1);
    bus.jmp = 0; bus.stall = 0;
    step(); check_pc("prio_br", 50, 1'b1);
    bus.br_taken = 0;

    // Halt, ignore stall/ret, exit via branch
    jump_to(10'd20, 1'b0);
    check_pc("jmp20", 20, 1'b1);
    bus.halt = 1'b1;
    step(); check_pc("halt", 20, 1'b0);
    check("halt_state", 32'(dbg_state), 2);
    bus.halt = 0; bus.stall = 1; bus.ret = 1;
    step(); check_pc("halt_hold1", 20, 1'b0);
    step(); check_pc("halt_hold2", 20, 1'b0);
    check("halt_uf", 32'(bus.ras_underflow), 0);
    bus.stall = 0; bus.ret = 0;
    bus.br_taken = 1; bus.br_target = 10'd300;
    step(); check_pc("halt_exit", 300, 1'b1);
    bus.br_taken = 0;
    step(); check_pc("post301", 301, 1'b1);
    step(); check_pc("post302", 302, 1'b1);

    // Halt and branch together: branch wins, stays in RUN
    bus.halt = 1; bus.br_taken = 1; bus.br_target = 10'd700;
    step(); check_pc("halt_br", 700, 1'b1);
    bus.halt = 0; bus.br_taken = 0;

    // Call / return
    jump_to(10'd10, 1'b0);
    jump_to(10'd100, 1'b1);
    check_pc("call100", 100, 1'b1);
    step(); step(); step();
    check_pc("at103", 103, 1'b1);
    bus.ret = 1;
    step(); check_pc("ret", RAS_ON ? 11 : 104, 1'b1);
    check("ret_uf", 32'(bus.ras_underflow), 0);
    step(); check_pc("ret_empty", RAS_ON ? 12 : 105, 1'b1);
    check("ret_empty_uf", 32'(bus.ras_underflow), 32'(RAS_ON));
    bus.ret = 0;
    step(); check_pc("after_uf", RAS_ON ? 13 : 106, 1'b1);
    check("uf_pulse_end", 32'(bus.ras_underflow), 0);

    // Five nested calls overflow a 4-deep stack; oldest return address is lost
    jump_to(10'd100, 1'b1);
    jump_to(10'd200, 1'b1);
    jump_to(10'd300, 1'b1);
    jump_to(10'd400, 1'b1);
    jump_to(10'd500, 1'b1);
    check_pc("nest5", 500, 1'b1);
    bus.ret = 1;
    step(); check_pc("nret1", RAS_ON ? 401 : 501, 1'b1);
    step(); check_pc("nret2", RAS_ON ? 301 : 502, 1'b1);
    step(); check_pc("nret3", RAS_ON ? 201 : 503, 1'b1);
    step(); check_pc("nret4", RAS_ON ? 101 : 504, 1'b1);
    check("nret4_uf", 32'(bus.ras_underflow), 0);
    step(); check_pc("nret5", RAS_ON ? 102 : 505, 1'b1);
    check("nret5_uf", 32'(bus.ras_underflow), 32'(RAS_ON));
    bus.ret = 0;
    step(); check_pc("nret_done", RAS_ON ? 103 : 506, 1'b1);
    check("nret_done_uf", 32'(bus.ras_underflow), 0);

    // Reset while halted with three entries on the stack
    jump_to(10'd600, 1'b1);
    jump_to(10'd610, 1'b1);
    jump_to(10'd620, 1'b1);
    bus.halt = 1;
    step(); check_pc("pre_rst_halt", 620, 1'b0);
    bus.halt = 0;
    reset = 1;
    step(); check_pc("mid_rst", 0, 1'b0);
    check("mid_rst_state", 32'(dbg_state), 0);
    reset = 0;
    step(); check_pc("mid_rst_run", 0, 1'b1);
    bus.ret = 1;
    step(); check_pc("rst_ret", 1, 1'b1);
    check("rst_ret_uf", 32'(bus.ras_underflow), 32'(RAS_ON));
    bus.ret = 0;
    step(); check_pc("rst_ret_done", 2, 1'b1);
    check("rst_ret_done_uf", 32'(bus.ras_underflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
